cpu_buttons_pio_in: RTL and testbench

Avalon-MM slave input PIO; the read-side counterpart of the write-only LED output PIOs on the Nios II system bus. Samples external push-buttons or switches and exposes their level to the CPU. Latches edges per bit and raises a maskable level interrupt to the Nios II IRQ line. One instance per button bank in the cpu system.

---
 rtl/cpu_buttons_pio_in.sv | 182 ++++++++++++++++++
 tb/tb_cpu_buttons_pio_in.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_buttons_pio_in.sv
// cpu_buttons_pio_in
// -----------------------------------------------------------------------------
// Avalon-MM slave input PIO for a bank of push-buttons / switches on the
// Nios II system bus. The raw inputs are brought into the clk domain through a
// two-flop synchronizer. Edges are latched per bit into edge_capture, which
// the CPU clears by writing ones. A maskable level interrupt is raised on irq.
//
// Register map (32-bit words on s1, unused upper bits read as 0):
//   0 : data         RO   filtered input level
//   1 : reserved     RO   reads 0, writes ignored
//   2 : irq_mask     RW   WIDTH bits
//   3 : edge_capture R/W1C; an edge arriving in the same cycle as a clear wins
//
// Ports:
//   clk         system clock (single domain)
//   reset_n     asynchronous active-low reset
//   address     s1 word address
//   chipselect  s1 select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     raw external inputs, asynchronous to clk
//   readdata    registered read data, read latency 1, updated every cycle
//   irq         active-high level interrupt = |(edge_capture & irq_mask)
//
// Optional feature: define CPU_BUTTONS_PIO_DEBOUNCE_EN to build a per-bit
// debouncer that accepts a new level only after it has been stable at the
// synchronizer output for DEBOUNCE_CYCLES cycles. Without the macro the
// filtered level is the synchronizer output and DEBOUNCE_CYCLES is unused.
// -----------------------------------------------------------------------------
module cpu_buttons_pio_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Elaboration-time parameter legality checks
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("cpu_buttons_pio_in: WIDTH must be in 1..32");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("cpu_buttons_pio_in: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] data_in_s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] rise_s, fall_s, edge_s, clr_s;
  logic             wr_s;
  logic             unused_wdata_s;

  // Only writedata[WIDTH-1:0] carries register content
  assign unused_wdata_s = ^writedata;

  // Synchronizer next-state: in_port is sampled here and nowhere else
  always_comb begin
    sync1_d = in_port;
    sync2_d = sync1_q;
  end

  // Two-flop synchronizer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= {WIDTH{1'b0}};
      sync2_q <= {WIDTH{1'b0}};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef CPU_BUTTONS_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;

  // Debounce next-state: any sample equal to the accepted level restarts the count
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = {CNT_W{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounce counters and accepted levels
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_in_s = stable_q;
`else
  assign data_in_s = sync2_q;
`endif

  // Edge detection, bus decode and register next-state
  always_comb begin
    rise_s = data_in_s & ~prev_q;
    fall_s = ~data_in_s & prev_q;
    case (EDGE_TYPE)
      32'sd0:  edge_s = rise_s;
      32'sd1:  edge_s = fall_s;
      default: edge_s = rise_s | fall_s;
    endcase

    wr_s = chipselect & ~write_n;
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    if (wr_s && (address == 2'd2)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else begin
      irq_mask_d = irq_mask_q;
    end

    // OR-ing the new edge after the clear makes a coincident edge survive
    edge_capture_d = (edge_capture_q & ~clr_s) | edge_s;
    prev_d         = data_in_s;

    readdata_d = 32'h0000_0000;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = data_in_s;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edge_capture_q;
      default: readdata_d = 32'h0000_0000;
    endcase
  end

  // Edge history, mask, capture and read data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q         <= {WIDTH{1'b0}};
      irq_mask_q     <= {WIDTH{1'b0}};
      edge_capture_q <= {WIDTH{1'b0}};
      readdata_q     <= 32'h0000_0000;
    end else begin
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Built only from register outputs so reset drops it without a clock
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_cpu_buttons_pio_in.sv
module tb_cpu_buttons_pio_in;
  localparam int W = 4;
`ifdef CPU_BUTTONS_PIO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif
  localparam int S = 4 + DB;

  logic         clk        = 1'b0;
  logic         reset_n    = 1'b1;
  logic [1:0]   address    = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [31:0]  writedata  = 32'h0;
  logic [W-1:0] in_port    = 4'h0;
  logic [31:0]  readdata;
  logic         irq;

  int n_cmp = 0;
  int n_err = 0;

  cpu_buttons_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: the filtered level is derived from a window of past
  // in_port samples; raw_h[k] is in_port as sampled k edges ago.
  logic [3:0]  raw_h [0:9];
  logic [3:0]  m_data = 4'h0, m_data_prev = 4'h0, m_mask = 4'h0, m_cap = 4'h0;
  logic [3:0]  d_new;
  logic [31:0] m_rd = 32'h0;
  logic        m_irq = 1'b0;
  bit          all_same;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 10; i++) raw_h[i] = 4'h0;
      m_data = 4'h0; m_data_prev = 4'h0; m_mask = 4'h0; m_cap = 4'h0;
      m_rd = 32'h0; m_irq = 1'b0;
    end else begin
      case (address)
        2'd0:    m_rd = {28'h0, m_data};
        2'd2:    m_rd = {28'h0, m_mask};
        2'd3:    m_rd = {28'h0, m_cap};
        default: m_rd = 32'h0;
      endcase
      if (chipselect && !write_n && address == 2'd3) m_cap = m_cap & ~writedata[3:0];
      m_cap = m_cap | (m_data ^ m_data_prev);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
      for (int i = 9; i > 0; i--) raw_h[i] = raw_h[i-1];
      raw_h[0] = in_port;
      if (DB == 0) begin
        d_new = raw_h[1];
      end else begin
        // accept a level once the synchronized input held it for 8 edges
        d_new = m_data;
        for (int b = 0; b < 4; b++) begin
          all_same = 1'b1;
          for (int j = 3; j <= 9; j++) if (raw_h[j][b] != raw_h[2][b]) all_same = 1'b0;
          if (all_same) d_new[b] = raw_h[2][b];
        end
      end
      m_data_prev = m_data;
      m_data      = d_new;
      m_irq       = |(m_cap & m_mask);
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    n_cmp++;
    if (readdata !== m_rd) begin
      n_err++;
      $display("FAIL model_readdata t=%0t: got 0x%08h expected 0x%08h", $time, readdata, m_rd);
    end
    n_cmp++;
    if (irq !== m_irq) begin
      n_err++;
      $display("FAIL model_irq t=%0t: got %0b expected %0b", $time, irq, m_irq);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] rd;
  int cnt;

  initial begin
    // 1. reset
    #1 reset_n = 1'b0;
    #2;
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    idle(3);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rd);
      chk($sformatf("reset_read_addr%0d", a), rd, 32'h0);
    end
    chk("reset_irq_after", {31'h0, irq}, 32'h0);

    // 2. level read
    in_port = 4'hA;
    idle(3 + DB);
    bus_read(2'd0, rd);  chk("level_read", rd, 32'h0000_000A);
    bus_read(2'd3, rd);  chk("level_capture", rd, 32'h0000_000A);
    chk("level_irq_masked", {31'h0, irq}, 32'h0);
    in_port = 4'h0;
    idle(S);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, rd);  chk("w1c_all", rd, 32'h0);

    // 3. capture and irq
    bus_write(2'd2, 32'h1);
    in_port = 4'h1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!irq && cnt < 40);
    chk("irq_latency", cnt, 3 + DB);
    bus_read(2'd3, rd);  chk("capture_bit0", rd, 32'h1);
    bus_write(2'd3, 32'h1);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);  chk("capture_cleared", rd, 32'h0);
    in_port = 4'h3;
    idle(S);
    bus_read(2'd3, rd);  chk("capture_bit1", rd, 32'h2);
    chk("irq_masked_bit1", {31'h0, irq}, 32'h0);
    bus_write(2'd2, 32'h3);
    chk("unmask_pending_irq", {31'h0, irq}, 32'h1);
    bus_write(2'd2, 32'h0);
    chk("mask_drops_irq", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rd);  chk("mask_keeps_capture", rd, 32'h2);
    bus_read(2'd2, rd);  chk("mask_readback", rd, 32'h0);

    // 4. simultaneous edge and clear
    in_port = 4'h8;
    idle(S);
    bus_read(2'd3, rd);  chk("pre_simul_capture", rd, 32'hB);
    in_port = 4'hC;
    repeat (2 + DB) @(negedge clk);
    address = 2'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'hF;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    bus_read(2'd3, rd);  chk("simul_set_wins", rd, 32'h4);

    // 5. glitch and debounce latency
    in_port = 4'h0;
    idle(S);
    bus_write(2'd3, 32'hF);
    bus_read(2'd3, rd);  chk("pre_glitch_capture", rd, 32'h0);
    in_port = 4'h8;
    idle(5);
    in_port = 4'h0;
    idle(20);
    bus_read(2'd0, rd);  chk("glitch_level", rd, 32'h0);
    bus_read(2'd3, rd);  chk("glitch_capture", rd, (DB != 0) ? 32'h0 : 32'h8);
    bus_write(2'd3, 32'hF);
    address = 2'd0; chipselect = 1'b1; in_port = 4'h8;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!readdata[3] && cnt < 40);
    chk("level_latency", cnt, 3 + DB);
    idle(20 - cnt);
    chipselect = 1'b0;
    in_port = 4'h0;
    idle(S);

    // 6. reset mid-operation
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'hF);
    in_port = 4'hF;
    idle(S);
    bus_read(2'd3, rd);  chk("pre_reset_capture", rd, 32'hF);
    chk("pre_reset_irq", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    in_port = 4'h0;
    #1;
    chk("irq_async_reset", {31'h0, irq}, 32'h0);
    chk("readdata_async_reset", readdata, 32'h0);
    idle(3);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rd);
      chk($sformatf("post_reset_addr%0d", a), rd, 32'h0);
    end
    chk("post_reset_irq", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
